// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t : receiver FSM state encoding
//   OVS        : s_tick count per data bit (16x oversampling)
//   MID_START  : s_cnt value at the middle of the start bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int OVS       = 16;
  localparam int MID_START = 7;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receive framer: 2-flop rx synchroniser, oversampled bit FSM and
// LSB-first shift register.
// Optional macro UART_RCVR_PARITY_EN adds a PARITY state and par_odd/par_fail.
//
// Ports
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   s_tick   : 16x baud oversampling strobe
//   rx       : raw serial input (asynchronous, idle high)
//   par_odd  : parity sense, 1 = odd (parity build only)
//   dout     : assembled byte
//   rx_done  : one-clk pulse, frame with valid stop bit completed
//   frm_fail : one-clk pulse, stop bit sampled low
//   par_fail : one-clk pulse, parity mismatch (parity build only)
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low (checked every clk)
// START  | counting to mid start bit, re-checking rx_s to reject glitches
// DATA   | sampling W data bits at the middle of each bit
// PARITY | sampling the parity bit (parity build only)
// STOP   | sampling the stop bit after SB_TICK ticks
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int W       = 8,
  parameter int SB_TICK = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_tick,
  input  logic         rx,
`ifdef UART_RCVR_PARITY_EN
  input  logic         par_odd,
  output logic         par_fail,
`endif
  output logic [W-1:0] dout,
  output logic         rx_done,
  output logic         frm_fail
);

  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (W > 1) ? $clog2(W) : 1;

  rx_state_t     state, state_nx;
  logic [SW-1:0] s_cnt, s_cnt_nx;
  logic [NW-1:0] n_cnt, n_cnt_nx;
  logic [W-1:0]  shreg, shreg_nx;
  logic          rx_meta, rx_s;

  // Synchroniser resets to the idle (high) level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s_cnt <= '0;
      n_cnt <= '0;
      shreg <= '0;
    end else begin
      state <= state_nx;
      s_cnt <= s_cnt_nx;
      n_cnt <= n_cnt_nx;
      shreg <= shreg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    s_cnt_nx = s_cnt;
    n_cnt_nx = n_cnt;
    shreg_nx = shreg;
    rx_done  = 1'b0;
    frm_fail = 1'b0;
`ifdef UART_RCVR_PARITY_EN
    par_fail = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          s_cnt_nx = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt == SW'(MID_START)) begin
            if (!rx_s) begin
              state_nx = DATA;
              s_cnt_nx = '0;
              n_cnt_nx = '0;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            s_cnt_nx = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt == SW'(OVS - 1)) begin
            shreg_nx = {rx_s, shreg[W-1:1]};
            s_cnt_nx = '0;
            if (n_cnt == NW'(W - 1)) begin
`ifdef UART_RCVR_PARITY_EN
              state_nx = PARITY;
`else
              state_nx = STOP;
`endif
            end else begin
              n_cnt_nx = n_cnt + 1'b1;
            end
          end else begin
            s_cnt_nx = s_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RCVR_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s_cnt == SW'(OVS - 1)) begin
            // Even parity: bit equals XOR of data; odd parity inverts it.
            par_fail = rx_s ^ (^shreg) ^ par_odd;
            s_cnt_nx = '0;
            state_nx = STOP;
          end else begin
            s_cnt_nx = s_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s_cnt == SW'(SB_TICK - 1)) begin
            if (rx_s) rx_done  = 1'b1;
            else      frm_fail = 1'b1;
            state_nx = IDLE;
          end else begin
            s_cnt_nx = s_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dout = shreg;

endmodule

// File: rtl/uart_rcvr_path.sv
// UART receive path: framer plus receive FIFO (first-word fall-through)
// and sticky error flags.
// Optional macro UART_RCVR_PARITY_EN adds par_odd input and par_err flag.
//
// Ports
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   s_tick    : 16x baud oversampling strobe
//   rx        : serial input, idle high
//   rd_uart   : pop FIFO head
//   err_clr   : clear sticky flags
//   r_data    : FIFO head byte
//   rx_empty  : FIFO empty
//   rx_full   : FIFO full
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, byte completed while FIFO full
//   par_odd   : parity sense (parity build only)
//   par_err   : sticky parity mismatch (parity build only)
module uart_rcvr_path
  import uart_pkg::*;
#(
  parameter int W       = 8,
  parameter int SB_TICK = 16,
  parameter int A       = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_tick,
  input  logic         rx,
  input  logic         rd_uart,
  input  logic         err_clr,
`ifdef UART_RCVR_PARITY_EN
  input  logic         par_odd,
  output logic         par_err,
`endif
  output logic [W-1:0] r_data,
  output logic         rx_empty,
  output logic         rx_full,
  output logic         frame_err,
  output logic         overrun
);

  localparam int DEPTH = 1 << A;

  logic [W-1:0] dout;
  logic         rx_done;
  logic         frm_fail;
`ifdef UART_RCVR_PARITY_EN
  logic         par_fail;
`endif

  uart_rx_fsm #(
    .W       (W),
    .SB_TICK (SB_TICK)
  ) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .s_tick   (s_tick),
    .rx       (rx),
`ifdef UART_RCVR_PARITY_EN
    .par_odd  (par_odd),
    .par_fail (par_fail),
`endif
    .dout     (dout),
    .rx_done  (rx_done),
    .frm_fail (frm_fail)
  );

  logic [W-1:0] mem [DEPTH];
  logic [A-1:0] wr_ptr, rd_ptr;
  logic [A:0]   count;
  logic         push, pop, drop;

  assign rx_empty = (count == '0);
  assign rx_full  = (count == (A+1)'(DEPTH));
  assign pop      = rd_uart && !rx_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push     = rx_done && (!rx_full || pop);
  assign drop     = rx_done && rx_full && !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dout;
        wr_ptr      <= wr_ptr + A'(1);
      end
      if (pop) rd_ptr <= rd_ptr + A'(1);
      case ({push, pop})
        2'b10:   count <= count + (A+1)'(1);
        2'b01:   count <= count - (A+1)'(1);
        default: ;
      endcase
    end
  end

  assign r_data = mem[rd_ptr];

  // Set wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frm_fail)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (drop)         overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end

`ifdef UART_RCVR_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        par_err <= 1'b0;
    else if (par_fail) par_err <= 1'b1;
    else if (err_clr)  par_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_rcvr_path.sv
// Directed bench for uart_rcvr_path: 8N1 frames at 16 clk per bit.
module tb_uart_rcvr_path;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b1;
  logic       rx = 1'b1;
  logic       rd_uart = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] r_data;
  logic       rx_empty, rx_full, frame_err, overrun;
`ifdef UART_RCVR_PARITY_EN
  logic       par_odd = 1'b0;
  logic       par_err;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  uart_rcvr_path #(.W(8), .SB_TICK(16), .A(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .s_tick    (s_tick),
    .rx        (rx),
    .rd_uart   (rd_uart),
    .err_clr   (err_clr),
`ifdef UART_RCVR_PARITY_EN
    .par_odd   (par_odd),
    .par_err   (par_err),
`endif
    .r_data    (r_data),
    .rx_empty  (rx_empty),
    .rx_full   (rx_full),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (u_dut.rx_done) done_cnt++;

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", rx_empty); end
    checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", rx_full); end
    checks++; if (r_data !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", r_data); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b want 00", frame_err, overrun); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single;
    bit seen;
    int d0;
    seen = 1'b0;
    d0 = done_cnt;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int i = 0; i < 250; i++) begin
          @(negedge clk);
          if (u_dut.rx_done) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL single_done_timeout: got none want rx_done"); end
        else begin
          checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL single_empty_at_done: got %b want 1", rx_empty); end
          @(negedge clk);
          checks++; if (rx_empty !== 1'b0) begin errors++; $display("FAIL single_empty_after: got %b want 0", rx_empty); end
          checks++; if (r_data !== 8'h55) begin errors++; $display("FAIL single_rdata: got %h want 55", r_data); end
        end
      end
    join
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL single_flags: got %b%b want 00", frame_err, overrun); end
    rd_uart = 1'b1; @(negedge clk); rd_uart = 1'b0;
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty: got %b want 1", rx_empty); end
  endtask

  task automatic test_glitch;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL glitch_done: got %0d want 0", done_cnt - d0); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL glitch_empty: got %b want 1", rx_empty); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_frame_err;
    int d0;
    d0 = done_cnt;
    send_frame(8'hA3, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b want 1", frame_err); end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ferr_empty: got %b want 1", rx_empty); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL ferr_done: got %0d want 0", done_cnt - d0); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
  endtask

  task automatic test_overrun;
    logic [7:0] b;
    for (int i = 1; i <= 5; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
      if (i < 4) begin
        checks++; if (rx_full !== 1'b0) begin errors++; $display("FAIL ovr_full_%0d: got %b want 0", i, rx_full); end
      end else if (i == 4) begin
        checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL ovr_full_4: got %b want 1", rx_full); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", overrun); end
      end else begin
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", overrun); end
        checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL ovr_full_5: got %b want 1", rx_full); end
      end
    end
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      checks++; if (r_data !== b) begin errors++; $display("FAIL ovr_pop_%0d: got %h want %h", i, r_data, b); end
      rd_uart = 1'b1; @(negedge clk); rd_uart = 1'b0;
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovr_drained: got %b want 1", rx_empty); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_full_pop;
    logic [7:0] exp [4];
    logic [7:0] fill [4];
    bit seen;
    fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
    exp[0]  = 8'h22; exp[1]  = 8'h33; exp[2]  = 8'h44; exp[3]  = 8'h77;
    for (int i = 0; i < 4; i++) send_frame(fill[i], 1'b1);
    checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL fp_full_before: got %b want 1", rx_full); end
    seen = 1'b0;
    fork
      send_frame(8'h77, 1'b1);
      begin
        for (int i = 0; i < 250; i++) begin
          @(negedge clk);
          if (u_dut.rx_done) begin seen = 1'b1; break; end
        end
        if (seen) begin
          rd_uart = 1'b1; @(negedge clk); rd_uart = 1'b0;
        end
      end
    join
    checks++; if (!seen) begin errors++; $display("FAIL fp_done_timeout: got none want rx_done"); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fp_overrun: got %b want 0", overrun); end
    checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL fp_full_after: got %b want 1", rx_full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (r_data !== exp[i]) begin errors++; $display("FAIL fp_pop_%0d: got %h want %h", i, r_data, exp[i]); end
      rd_uart = 1'b1; @(negedge clk); rd_uart = 1'b0;
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL fp_drained: got %b want 1", rx_empty); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    int d0;
    b = 8'hC4;
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    reset = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rm_empty_in_reset: got %b want 1", rx_empty); end
    reset = 1'b1;
    repeat (40) @(negedge clk);
    d0 = done_cnt;
    send_frame(8'h3C, 1'b1);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rm_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (r_data !== 8'h3C) begin errors++; $display("FAIL rm_rdata: got %h want 3c", r_data); end
    checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rm_flags: got %b%b want 00", frame_err, overrun); end
    rd_uart = 1'b1; @(negedge clk); rd_uart = 1'b0;
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL rm_only_one: got %b want 1", rx_empty); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_glitch;
    test_frame_err;
    test_overrun;
    test_full_pop;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rcvr_path.md
Name: uart_rcvr_path

Overview:
Receive-side counterpart of the UART transmitter subsystem. Synchronises the serial rx line and recovers 8N1 frames (LSB first) using 16x oversampling on s_tick. Received bytes are pushed into an internal FIFO that the host reads via rd_uart. Framing and overrun conditions are reported as sticky status flags. Shares the baud-rate tick generator with the transmitter path.

Parameters:
W, 8, data bits per frame
SB_TICK, 16, s_ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
A, 2, FIFO address width; depth = 2^A

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
s_tick  in  1  16x baud oversampling strobe, one clk wide
rx  in  1  serial input; asynchronous to clk; idle high
rd_uart  in  1  pop the head byte from the FIFO
err_clr  in  1  clear frame_err and overrun
r_data  out  W  FIFO head byte (first-word fall-through)
rx_empty  out  1  FIFO empty
rx_full  out  1  FIFO full
frame_err  out  1  sticky: stop bit sampled as 0
overrun  out  1  sticky: byte completed while FIFO full

Behaviour:
- Reset (reset=0, asynchronous assertion):
  - Synchroniser flops to 1; FSM to IDLE; s_cnt, n_cnt, shift register to 0.
  - FIFO pointers to 0; rx_empty=1, rx_full=0, r_data=0 (storage cleared).
  - frame_err=0, overrun=0.
  - Reset mid-frame abandons the partial byte; no push occurs.
- rx passes through a 2-flop synchroniser (rx_s), adding 2 clk of latency; the FSM uses only rx_s.
- FSM states, counters advancing only on s_tick unless noted:
  - IDLE: rx_s==0 (checked every clk) -> START, s_cnt=0.
  - START: at s_cnt==7 (mid start bit): if rx_s==0 -> DATA with s_cnt=0, n_cnt=0; if rx_s==1 -> IDLE (glitch rejected, no flag). Otherwise s_cnt++.
  - DATA: at s_cnt==15: shift register = {rx_s, shreg[W-1:1]}, s_cnt=0; if n_cnt==W-1 -> STOP, else n_cnt++. Otherwise s_cnt++.
  - STOP: at s_cnt==SB_TICK-1: if rx_s==1, assert rx_done for one clk; if rx_s==0, set frame_err and discard the byte. Either way -> IDLE. Otherwise s_cnt++.
- FIFO push on rx_done:
  - If not full, write the byte and advance the write pointer.
  - If full, drop the byte and set overrun.
  - Full-with-simultaneous-pop: the pop frees space, so the push succeeds and no overrun is raised.
- FIFO pop:
  - rd_uart with !rx_empty advances the read pointer; r_data shows the next entry in the following cycle.
  - rd_uart while empty is ignored.
  - Push and pop together while empty: push only.
  - Push and pop together while neither empty nor full: both occur, occupancy unchanged.
- Latency: byte appears on r_data and rx_empty falls 1 clk after rx_done.
- Flags:
  - Set has priority over err_clr in the same cycle.
  - err_clr otherwise clears both flags on the next clk.
- Pointer wrap-around is modulo 2^A.
- full = occupancy == 2^A; empty = occupancy == 0. Occupancy is tracked with an (A+1)-bit count or with extra pointer MSBs.

Optional Feature:
- Macro: UART_RCVR_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP and samples the parity bit at s_cnt==15.
  - New input par_odd (1 = odd parity, 0 = even) and new output par_err (sticky, cleared by err_clr).
  - A parity mismatch sets par_err; the byte is still pushed if the stop bit is valid.
- When undefined: no PARITY state and no par_odd/par_err ports; behaviour is exactly 8N1 as above.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding constants (IDLE, START, DATA, PARITY, STOP).
  - OVS = 16 and MID_START = 7.
- Natural sub-module: uart_rx_fsm (synchroniser, FSM, shift register; outputs dout and rx_done).
- The FIFO stays inline in uart_rcvr_path, or reuses the team's existing FIFO buffer block if its reset polarity is adapted.

Test Plan:
- Frame 0x55 (s_tick every clk, 16 ticks/bit) -> rx_done once; r_data=0x55; rx_empty falls 1 clk later; both flags 0.
- 3-clk low glitch on idle rx -> FSM returns to IDLE at the mid-start check; no push; rx_empty stays 1.
- Frame 0xA3 with stop bit forced 0 -> frame_err=1; FIFO unchanged. Pulse err_clr -> frame_err=0.
- Five frames 0x01..0x05 with no reads (A=2) -> rx_full=1 after the 4th, overrun=1 after the 5th. Then 4 pops yield 0x01, 0x02, 0x03, 0x04 and rx_empty=1.
- FIFO full, with rd_uart asserted in the same clk as rx_done of 0x77 -> overrun stays 0; rx_full stays 1; 0x77 is read last.
- Assert reset mid-DATA of 0xC4, then release and send 0x3C -> FIFO contains only 0x3C; flags 0.
